ssd_display_arbiter: RTL

- Shares the single 8-digit seven-segment display between two requesters, for example a MicroBlaze GPIO client and a hardware status client.
- Each client drives a request plus its own data/control words; the block grants one client at a time.
- Fairness rules: minimum hold time per grant, round-robin under contention.
- Drives the 32-bit data and 9-bit control (dp[7:0], blank[8]) inputs of the seven-segment display driver, with registered outputs.

---
 rtl/ssd_display_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ssd_display_arbiter.sv
// Two-client arbiter for the shared 8-digit seven-segment display: minimum hold, round-robin on ties.
// Optional build macro SSD_ARB_IDLE_BLANK_EN blanks the display while idle; otherwise it freezes.
module ssd_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter logic [31:0] IDLE_DATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic [8:0]  ctrl0,
    input  logic        req1,
    input  logic [31:0] data1,
    input  logic [8:0]  ctrl1,
    output logic [1:0]  grant,
    output logic        hold_done,
    output logic [31:0] data_out,
    output logic [8:0]  control_out
);

    localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [8:0] CTRL_BLANK = 9'h100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic              hold_done_q, hold_done_d;
    logic [31:0]       data_out_q, data_out_d;
    logic [8:0]        control_out_q, control_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= 1'b1;
            grant_q       <= 2'b00;
            hold_done_q   <= 1'b0;
            data_out_q    <= IDLE_DATA;
            control_out_q <= CTRL_BLANK;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            hold_done_q   <= hold_done_d;
            data_out_q    <= data_out_d;
            control_out_q <= control_out_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        data_out_d    = data_out_q;
        control_out_d = control_out_q;

        // An owner dropping its request always wins over hold-based preemption.
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
                else if (req0)     state_d = OWN0;
                else if (req1)     state_d = OWN1;
            end
            OWN0: begin
                if (!req0)                     state_d = req1 ? OWN1 : IDLE;
                else if (hold_done_q && req1)  state_d = OWN1;
            end
            OWN1: begin
                if (!req1)                     state_d = req0 ? OWN0 : IDLE;
                else if (hold_done_q && req0)  state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE || state_d != state_q) cnt_d = '0;
        else if (cnt_q != HOLD_MAX)                cnt_d = cnt_q + CNT_W'(1);

        if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;

        grant_d     = {state_d == OWN1, state_d == OWN0};
        hold_done_d = (state_d != IDLE) && (cnt_d == HOLD_MAX);

        // Data follows the next owner so it changes on the same edge as grant.
        case (state_d)
            OWN0: begin
                data_out_d    = data0;
                control_out_d = ctrl0;
            end
            OWN1: begin
                data_out_d    = data1;
                control_out_d = ctrl1;
            end
            default: begin
`ifdef SSD_ARB_IDLE_BLANK_EN
                data_out_d    = 32'h0;
                control_out_d = CTRL_BLANK;
`else
                data_out_d    = data_out_q;
                control_out_d = control_out_q;
`endif
            end
        endcase
    end

    assign grant       = grant_q;
    assign hold_done   = hold_done_q;
    assign data_out    = data_out_q;
    assign control_out = control_out_q;

endmodule
